// File: rtl/fetch_unit_l2.sv
// In-order instruction fetch stage: owns the PC, keeps up to p_max_in_flight
// memory requests outstanding, buffers responses in order and squashes on redirect.
module fetch_unit_l2 #(
   parameter logic [31:0] p_rst_addr      = 32'h200,
   parameter int          p_max_in_flight = 2,
   parameter int          p_seq_num_bits  = 5
) (
   input  logic                      clk,
   input  logic                      rst,
   output logic                      mem_req_val,
   input  logic                      mem_req_rdy,
   output logic [31:0]               mem_req_addr,
   input  logic                      mem_resp_val,
   output logic                      mem_resp_rdy,
   input  logic [31:0]               mem_resp_data,
   output logic                      D_val,
   input  logic                      D_rdy,
   output logic [31:0]               D_inst,
   output logic [31:0]               D_pc,
   output logic [p_seq_num_bits-1:0] D_seq_num,
   input  logic                      redirect_val,
   input  logic [31:0]               redirect_target
);

   localparam int DEPTH = p_max_in_flight;
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW    = $clog2(DEPTH + 1);

   logic [31:0]               pc_q, pc_d;
   logic [CW-1:0]             in_flight_q, in_flight_d;
   logic [CW-1:0]             drop_q, drop_d;
   logic [p_seq_num_bits-1:0] seq_num_q, seq_num_d;

   logic [31:0]   rf_inst_q [DEPTH];
   logic [31:0]   rf_inst_d [DEPTH];
   logic [31:0]   rf_pc_q [DEPTH];
   logic [31:0]   rf_pc_d [DEPTH];
   logic [PW-1:0] rf_wr_q, rf_wr_d, rf_rd_q, rf_rd_d;
   logic [CW-1:0] rf_cnt_q, rf_cnt_d;

   // Pending-PC fifo occupancy is in_flight itself, so it needs no counter.
   logic [31:0]   pf_pc_q [DEPTH];
   logic [31:0]   pf_pc_d [DEPTH];
   logic [PW-1:0] pf_wr_q, pf_wr_d, pf_rd_q, pf_rd_d;

   logic [CW:0] occ;
   logic        req_xfer;
   logic        resp_fire;
   logic        resp_keep;
   logic        d_xfer;
   logic [31:0] resp_pc;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign occ          = {1'b0, in_flight_q} + {1'b0, rf_cnt_q};
   assign mem_req_val  = !rst && !redirect_val && (occ < (CW+1)'(DEPTH));
   assign mem_req_addr = pc_q;
   assign req_xfer     = mem_req_val && mem_req_rdy;
   assign mem_resp_rdy = !rst;
   // Guard against stray responses from before a reset underflowing the count.
   assign resp_fire    = mem_resp_val && mem_resp_rdy && (in_flight_q != '0);
   assign resp_keep    = resp_fire && (drop_q == '0) && !redirect_val;
   assign resp_pc      = pf_pc_q[pf_rd_q];

   assign D_val     = !rst && (rf_cnt_q != '0) && !redirect_val;
   assign D_inst    = rf_inst_q[rf_rd_q];
   assign D_pc      = rf_pc_q[rf_rd_q];
   assign D_seq_num = seq_num_q;
   assign d_xfer    = D_val && D_rdy;

   always_comb begin
      pc_d      = pc_q;
      drop_d    = drop_q;
      seq_num_d = seq_num_q;
      rf_inst_d = rf_inst_q;
      rf_pc_d   = rf_pc_q;
      rf_wr_d   = rf_wr_q;
      rf_rd_d   = rf_rd_q;
      pf_pc_d   = pf_pc_q;
      pf_wr_d   = pf_wr_q;
      pf_rd_d   = pf_rd_q;

      in_flight_d = in_flight_q + CW'(req_xfer) - CW'(resp_fire);
      rf_cnt_d    = rf_cnt_q + CW'(resp_keep) - CW'(d_xfer);

      if (req_xfer) begin
         pf_pc_d[pf_wr_q] = pc_q;
         pf_wr_d          = ptr_inc(pf_wr_q);
         pc_d             = pc_q + 32'd4;
      end

      if (resp_fire) begin
         pf_rd_d = ptr_inc(pf_rd_q);
         if (drop_q != '0) drop_d = drop_q - CW'(1);
      end

      if (resp_keep) begin
         rf_inst_d[rf_wr_q] = mem_resp_data;
         rf_pc_d[rf_wr_q]   = resp_pc;
         rf_wr_d            = ptr_inc(rf_wr_q);
      end

      if (d_xfer) begin
         rf_rd_d   = ptr_inc(rf_rd_q);
         seq_num_d = seq_num_q + p_seq_num_bits'(1);
      end

      // No request issues in a redirect cycle, so every remaining outstanding
      // request (in_flight_d) belongs to the squashed path.
      if (redirect_val) begin
         pc_d     = redirect_target;
         rf_cnt_d = '0;
         rf_wr_d  = '0;
         rf_rd_d  = '0;
         drop_d   = in_flight_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q        <= p_rst_addr;
         in_flight_q <= '0;
         drop_q      <= '0;
         seq_num_q   <= '0;
         rf_wr_q     <= '0;
         rf_rd_q     <= '0;
         rf_cnt_q    <= '0;
         pf_wr_q     <= '0;
         pf_rd_q     <= '0;
      end else begin
         pc_q        <= pc_d;
         in_flight_q <= in_flight_d;
         drop_q      <= drop_d;
         seq_num_q   <= seq_num_d;
         rf_wr_q     <= rf_wr_d;
         rf_rd_q     <= rf_rd_d;
         rf_cnt_q    <= rf_cnt_d;
         pf_wr_q     <= pf_wr_d;
         pf_rd_q     <= pf_rd_d;
      end
   end

   always_ff @(posedge clk) begin
      rf_inst_q <= rf_inst_d;
      rf_pc_q   <= rf_pc_d;
      pf_pc_q   <= pf_pc_d;
   end

endmodule

// File: tb/tb_fetch_unit_l2.sv
// Bench for fetch_unit_l2: randomized memory/decode/redirect traffic checked
// every cycle against a queue-based model of outstanding and buffered fetches.
module tb_fetch_unit_l2;

   localparam int MAXF = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_req_val;
   logic        mem_req_rdy = 1'b0;
   logic [31:0] mem_req_addr;
   logic        mem_resp_val = 1'b0;
   logic        mem_resp_rdy;
   logic [31:0] mem_resp_data = '0;
   logic        D_val;
   logic        D_rdy = 1'b0;
   logic [31:0] D_inst;
   logic [31:0] D_pc;
   logic [4:0]  D_seq_num;
   logic        redirect_val = 1'b0;
   logic [31:0] redirect_target = '0;

   fetch_unit_l2 dut (
      .clk            (clk),
      .rst            (rst),
      .mem_req_val    (mem_req_val),
      .mem_req_rdy    (mem_req_rdy),
      .mem_req_addr   (mem_req_addr),
      .mem_resp_val   (mem_resp_val),
      .mem_resp_rdy   (mem_resp_rdy),
      .mem_resp_data  (mem_resp_data),
      .D_val          (D_val),
      .D_rdy          (D_rdy),
      .D_inst         (D_inst),
      .D_pc           (D_pc),
      .D_seq_num      (D_seq_num),
      .redirect_val   (redirect_val),
      .redirect_target(redirect_target)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      int          due;
      bit          squash;
   } req_t;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
   } buf_t;

   req_t        outq[$];
   buf_t        bufq[$];
   logic [31:0] exp_pc  = 32'h200;
   logic [4:0]  exp_seq = '0;
   int          cyc     = 0;
   int          n_deliv = 0;
   int          n_chk   = 0;
   int          n_pass  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
   endtask

   // mode 0: random redirects; 1: one redirect to 0x400 with two requests
   // outstanding; 2: one redirect to 0x400 in a response cycle with D_rdy=1.
   task automatic run(input int n, input int lat_lo, input int lat_hi, input int rdy_pct,
                      input int drdy_pct, input int redir_pct, input int mode);
      bit   fired = 0;
      bit   resp, redir, exp_req, exp_dval;
      req_t h, r;
      buf_t b;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rst = 1'b0;
         cyc++;
         resp          = (outq.size() > 0) && (outq[0].due <= cyc);
         mem_resp_val  = resp;
         mem_resp_data = resp ? ~outq[0].pc : $urandom;
         mem_req_rdy   = ($urandom_range(99) < rdy_pct);
         D_rdy         = ($urandom_range(99) < drdy_pct);
         redir         = ($urandom_range(99) < redir_pct);
         if (mode == 1 && !fired && outq.size() == 2) begin
            redir = 1; fired = 1;
         end
         if (mode == 2 && !fired && resp && bufq.size() > 0) begin
            redir = 1; D_rdy = 1'b1; fired = 1;
         end
         redirect_val    = redir;
         redirect_target = (mode != 0) ? 32'h400 : 32'h1000 + ($urandom_range(255) << 2);
         #1;
         exp_req = !redir && (outq.size() + bufq.size() < MAXF);
         chk("req_val", mem_req_val, exp_req);
         if (exp_req) chk("req_addr", mem_req_addr, exp_pc);
         chk("resp_rdy", mem_resp_rdy, 32'd1);
         exp_dval = !redir && (bufq.size() > 0);
         chk("d_val", D_val, exp_dval);
         if (exp_dval) begin
            chk("d_pc", D_pc, bufq[0].pc);
            chk("d_inst", D_inst, bufq[0].inst);
            chk("d_seq", D_seq_num, exp_seq);
         end
         if (exp_dval && D_rdy) begin
            void'(bufq.pop_front());
            exp_seq++;
            n_deliv++;
         end
         if (resp) begin
            h = outq.pop_front();
            if (!h.squash && !redir) begin
               b.inst = mem_resp_data;
               b.pc   = h.pc;
               bufq.push_back(b);
            end
         end
         if (exp_req && mem_req_rdy) begin
            r.pc     = exp_pc;
            r.due    = cyc + $urandom_range(lat_hi, lat_lo);
            r.squash = 0;
            outq.push_back(r);
            exp_pc += 32'd4;
         end
         if (redir) begin
            bufq.delete();
            foreach (outq[k]) outq[k].squash = 1;
            exp_pc = redirect_target;
         end
      end
   endtask

   initial begin
      repeat (3) begin
         @(negedge clk);
         #1;
         chk("rst_req_val", mem_req_val, 32'd0);
         chk("rst_resp_rdy", mem_resp_rdy, 32'd0);
         chk("rst_d_val", D_val, 32'd0);
      end
      run(20, 1, 1, 100, 100, 0, 0);   // free run, 1-cycle memory
      run(5, 1, 1, 100, 0, 0, 0);      // decode stalled
      run(20, 1, 1, 100, 100, 0, 0);   // release
      run(40, 3, 3, 50, 100, 0, 0);    // latency 3, toggling mem_req_rdy
      run(20, 3, 3, 100, 100, 0, 1);   // redirect with two outstanding
      run(20, 1, 1, 100, 100, 0, 0);
      run(20, 1, 2, 100, 100, 0, 2);   // redirect coinciding with a response
      run(600, 1, 3, 70, 70, 6, 0);    // mixed random traffic
      run(30, 1, 1, 100, 100, 0, 0);
      chk("seq_wrapped", (n_deliv > 40) ? 32'd1 : 32'd0, 32'd1);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
